// File: rtl/warmboot_pkg.sv
// Shared definitions for the warm-boot sequencer: default parameters and
// the FSM state encoding used by warmboot_ctrl.
package warmboot_pkg;

    // Default build parameters for the south-edge WARMBOOT tile.
    localparam int DEF_NUM_SLOTS      = 4;
    localparam int DEF_SLOT_W         = 2;
    localparam int DEF_SETUP_CYCLES   = 2;
    localparam int DEF_PULSE_CYCLES   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_CNT_W          = 11;

    // Fixed state encodings, kept stable so older tooling and debug scripts
    // that decode the raw state register keep working.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETUP     = 3'd1;
    localparam logic [2:0] ST_PULSE     = 3'd2;
    localparam logic [2:0] ST_WAIT_DROP = 3'd3;
    localparam logic [2:0] ST_WAIT_CFG  = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SETUP     = ST_SETUP,
        PULSE     = ST_PULSE,
        WAIT_DROP = ST_WAIT_DROP,
        WAIT_CFG  = ST_WAIT_CFG
    } state_e;

    // Terminal count for a phase lasting n cycles (counter starts at 0).
    function automatic int last_index(input int n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/warmboot_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the UserCLK
// domain. Both stages clear asynchronously to 0.
module warmboot_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through the metastability stage into q.
    // NOTE: clocked state always uses <= so every flop samples pre-edge values;
    // a blocking '=' here would collapse the two stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/warmboot_ctrl.sv
// Warm-boot sequencer: accepts a synchronised boot request from fabric logic,
// validates and holds the slot index, issues a timed BOOT_top strobe, then
// follows CONFIGURED_top low and high again to report completion or timeout.
module warmboot_ctrl
    import warmboot_pkg::*;
#(
    parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
    parameter int SLOT_W         = DEF_SLOT_W,
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              UserCLK,
    input  logic              RESET,
    input  logic              BOOT,
    input  logic [SLOT_W-1:0] SLOT,
    input  logic              CONFIGURED_top,
    output logic              BOOT_top,
    output logic [SLOT_W-1:0] SLOT_top,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    // Terminal counts for each timed phase.
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(last_index(SETUP_CYCLES));
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(last_index(PULSE_CYCLES));
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(last_index(TIMEOUT_CYCLES));
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    // Only a slot range that does not fill the index width can hold invalid
    // codes; for a power-of-two slot count the check folds to constant 0.
    localparam bit               SLOT_SPARSE  = (NUM_SLOTS < (1 << SLOT_W));

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic       boot_s;
    logic       boot_s_d;
    logic       cfg_s;
    logic [1:0] sync_primed;
    logic       boot_rise;
    logic       slot_invalid;
    logic       timeout;

    logic cnt_clr;
    logic boot_top_nxt;
    logic slot_load;
    logic err_set;
    logic err_clr;
    logic done_nxt;

    warmboot_sync2 u_boot_sync (
        .clk (UserCLK),
        .rst (RESET),
        .d   (BOOT),
        .q   (boot_s)
    );

    warmboot_sync2 u_cfg_sync (
        .clk (UserCLK),
        .rst (RESET),
        .d   (CONFIGURED_top),
        .q   (cfg_s)
    );

    // Edge history for the boot request. Until the synchroniser has flushed
    // its reset zeros the history is forced high, so a BOOT level held across
    // reset release is not mistaken for a fresh request: a low is needed first.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            sync_primed <= 2'b00;
            boot_s_d    <= 1'b1;
        end else begin
            sync_primed <= {sync_primed[0], 1'b1};
            boot_s_d    <= boot_s | ~sync_primed[1];
        end
    end

    assign boot_rise    = boot_s & ~boot_s_d;
    assign slot_invalid = SLOT_SPARSE && (int'(SLOT) >= NUM_SLOTS);
    assign timeout      = TIMEOUT_EN && (cnt == TIMEOUT_LAST);

    // Next-state and output-update decode; exits are tested before timeout so
    // an exit landing on the timeout cycle wins.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        cnt_clr      = 1'b0;
        boot_top_nxt = BOOT_top;
        slot_load    = 1'b0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        done_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                if (boot_rise) begin
                    if (slot_invalid) begin
                        err_set = 1'b1;
                    end else begin
                        slot_load = 1'b1;
                        err_clr   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    boot_top_nxt = 1'b1;
                    cnt_clr      = 1'b1;
                    state_nxt    = PULSE;
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    boot_top_nxt = 1'b0;
                    cnt_clr      = 1'b1;
                    state_nxt    = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!cfg_s) begin
                    cnt_clr   = 1'b1;
                    state_nxt = WAIT_CFG;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_CFG: begin
                if (cfg_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                boot_top_nxt = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
    end

    // State register and the phase counter, which saturates instead of wrapping.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state != IDLE && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered outputs; BOOT_top clears asynchronously with RESET.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            BOOT_top <= 1'b0;
            SLOT_top <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            BOOT_top <= boot_top_nxt;
            BUSY     <= (state_nxt != IDLE);
            DONE     <= done_nxt;
            if (slot_load) begin
                SLOT_top <= SLOT;
            end
            if (err_set) begin
                ERR <= 1'b1;
            end else if (err_clr) begin
                ERR <= 1'b0;
            end
        end
    end

endmodule
